// File: rtl/player_arbiter.sv
// Turn and move scheduler for the two-board 2048 game: latches keypad requests,
// grants one move at a time to the move engine and drives the display mode word.
module player_arbiter #(
  parameter int TURN_TICKS   = 30,
  parameter int DONE_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_i,
  input  logic [1:0] mode_sel_i,
  input  logic       restart_i,
  input  logic [3:0] req1_i,
  input  logic [3:0] req2_i,
  input  logic       move_done_i,
  input  logic       over1_i,
  input  logic       over2_i,
  output logic       move_start_o,
  output logic [3:0] move_dir_o,
  output logic       move_player_o,
  output logic [3:0] mode_o,
  output logic [4:0] turn_left_o,
  output logic [1:0] winner_o,
  output logic       err_o
);

  typedef enum logic [2:0] {IDLE, GRANT, ISSUE, WAIT_DONE, SWITCH, OVER} state_e;

  localparam logic [4:0] TURN_RELOAD = 5'(TURN_TICKS);
  localparam logic [7:0] WD_LAST     = 8'(DONE_TIMEOUT - 1);

  state_e     state_q;
  logic [1:0] modeSel_q;
  logic [3:0] slot1_q, slot2_q, slot1_d, slot2_d;
  logic       rr_q, turn_q;
  logic [4:0] turnLeft_q;
  logic [7:0] watchdog_q;
  logic [3:0] moveDir_q;
  logic       movePlayer_q;
  logic [1:0] winner_q;
  logic       err_q;

  logic       busy, versus, alternating, roundRobin;
  logic       gameOver, grantValid, grantPlayer, dispPlayer;
  logic [3:0] grantDir;
  logic       accept1, accept2;

  function automatic logic [3:0] prioReduce(input logic [3:0] r);
    logic [3:0] o;
    o = 4'b0000;
    if (r[3])      o = 4'b1000;
    else if (r[2]) o = 4'b0100;
    else if (r[1]) o = 4'b0010;
    else if (r[0]) o = 4'b0001;
    return o;
  endfunction

  always_comb begin
    busy        = (state_q == ISSUE) || (state_q == WAIT_DONE);
    versus      = modeSel_q[1];
    alternating = (modeSel_q == 2'b10);
    roundRobin  = (modeSel_q == 2'b11);

    if (versus) gameOver = over1_i | over2_i;
    else        gameOver = modeSel_q[0] ? over2_i : over1_i;

    grantPlayer = 1'b0;
    grantValid  = 1'b0;
    if (roundRobin) begin
      if ((slot1_q != 4'b0) && (slot2_q != 4'b0)) grantPlayer = rr_q;
      else                                         grantPlayer = (slot1_q == 4'b0);
      grantValid = (slot1_q != 4'b0) || (slot2_q != 4'b0);
    end else begin
      grantPlayer = alternating ? turn_q : modeSel_q[0];
      grantValid  = grantPlayer ? (slot2_q != 4'b0) : (slot1_q != 4'b0);
    end
    grantDir = grantPlayer ? slot2_q : slot1_q;

    // Drop requests into a full slot, from the in-flight player, or out of turn
    accept1 = (req1_i != 4'b0) && (slot1_q == 4'b0) && !(busy && !movePlayer_q)
              && !(alternating && turn_q);
    accept2 = (req2_i != 4'b0) && (slot2_q == 4'b0) && !(busy && movePlayer_q)
              && !(alternating && !turn_q);

    slot1_d = slot1_q;
    slot2_d = slot2_q;
    if (state_q == ISSUE && !movePlayer_q) slot1_d = 4'b0;
    if (state_q == ISSUE &&  movePlayer_q) slot2_d = 4'b0;
    if (accept1) slot1_d = prioReduce(req1_i);
    if (accept2) slot2_d = prioReduce(req2_i);

    if (busy)             dispPlayer = movePlayer_q;
    else if (alternating) dispPlayer = turn_q;
    else if (roundRobin)  dispPlayer = rr_q;
    else                  dispPlayer = modeSel_q[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      modeSel_q    <= 2'b00;
      slot1_q      <= 4'b0;
      slot2_q      <= 4'b0;
      rr_q         <= 1'b0;
      turn_q       <= 1'b0;
      turnLeft_q   <= TURN_RELOAD;
      watchdog_q   <= 8'd0;
      moveDir_q    <= 4'b0;
      movePlayer_q <= 1'b0;
      winner_q     <= 2'b00;
      err_q        <= 1'b0;
    end else begin
      slot1_q <= slot1_d;
      slot2_q <= slot2_d;
      if (restart_i) begin
        state_q    <= IDLE;
        winner_q   <= 2'b00;
        turnLeft_q <= TURN_RELOAD;
      end else begin
        case (state_q)
          IDLE: begin
            modeSel_q <= mode_sel_i;
            slot1_q   <= 4'b0;
            slot2_q   <= 4'b0;
            state_q   <= GRANT;
          end
          GRANT: begin
            if (gameOver) begin
              winner_q <= versus ? {over1_i, over2_i} : 2'b00;
              state_q  <= OVER;
            end else begin
              if (alternating && tick_i && turnLeft_q != 5'd0)
                turnLeft_q <= turnLeft_q - 5'd1;
              if (grantValid) begin
                moveDir_q    <= grantDir;
                movePlayer_q <= grantPlayer;
                state_q      <= ISSUE;
              end else if (alternating && tick_i && turnLeft_q == 5'd1) begin
                state_q <= SWITCH;
              end
            end
          end
          ISSUE: begin
            watchdog_q <= 8'd1;
            state_q    <= WAIT_DONE;
          end
          // Completion beats the watchdog when both land in the same cycle
          WAIT_DONE: begin
            if (move_done_i) begin
              state_q <= SWITCH;
            end else if (watchdog_q >= WD_LAST) begin
              err_q   <= 1'b1;
              state_q <= SWITCH;
            end else begin
              watchdog_q <= watchdog_q + 8'd1;
            end
          end
          SWITCH: begin
            if (roundRobin) rr_q <= ~movePlayer_q;
            if (alternating) begin
              turn_q     <= ~turn_q;
              turnLeft_q <= TURN_RELOAD;
            end
            state_q <= GRANT;
          end
          OVER:    state_q <= OVER;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign move_start_o  = (state_q == ISSUE);
  assign move_dir_o    = moveDir_q;
  assign move_player_o = movePlayer_q;
  assign mode_o        = {busy, state_q == OVER, modeSel_q[1], dispPlayer};
  assign turn_left_o   = turnLeft_q;
  assign winner_o      = winner_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_player_arbiter.sv
// Self-checking bench for player_arbiter: randomized scenarios against a
// transaction-level model of the turn, grant and game-over rules.
module tb_player_arbiter;
  localparam int TT = 3;
  localparam int DT = 255;

  logic       clk = 1'b0;
  logic       rst_n, tick, restart, move_done, over1, over2;
  logic [1:0] mode_sel;
  logic [3:0] req1, req2;
  logic       move_start, move_player, err;
  logic [3:0] move_dir, mode;
  logic [4:0] turn_left;
  logic [1:0] winner;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  player_arbiter #(.TURN_TICKS(TT), .DONE_TIMEOUT(DT)) dut (
    .clk(clk), .rst_n(rst_n), .tick_i(tick), .mode_sel_i(mode_sel),
    .restart_i(restart), .req1_i(req1), .req2_i(req2), .move_done_i(move_done),
    .over1_i(over1), .over2_i(over2), .move_start_o(move_start),
    .move_dir_o(move_dir), .move_player_o(move_player), .mode_o(mode),
    .turn_left_o(turn_left), .winner_o(winner), .err_o(err)
  );

  // Highest-priority key (up is the MSB) as a one-hot direction
  function automatic logic [3:0] expDir(input logic [3:0] r);
    for (int i = 3; i >= 0; i--) if (r[i]) return 4'b0001 << i;
    return 4'b0000;
  endfunction

  function automatic logic [1:0] expWinner(input logic o1, input logic o2);
    if (o1 && o2) return 2'b11;
    if (o2)       return 2'b01;
    if (o1)       return 2'b10;
    return 2'b00;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input logic [1:0] m);
    rst_n = 1'b0; tick = 0; restart = 0; move_done = 0; over1 = 0; over2 = 0;
    req1 = 4'b0; req2 = 4'b0; mode_sel = m;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic waitStart(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (move_start === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic finishMove(input int delay);
    repeat (delay) cyc();
    move_done = 1'b1;
    cyc();
    move_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick = 0; restart = 0; move_done = 0; over1 = 0; over2 = 0;
    req1 = 4'b0; req2 = 4'b0; mode_sel = 2'b11;
    cyc();
    testsRun++;
    if ({move_start, move_dir, move_player, mode, winner, err} !== 13'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got %b expected all zero",
               {move_start, move_dir, move_player, mode, winner, err});
    end
    testsRun++;
    if (turn_left !== 5'(TT)) begin
      testsFailed++;
      $display("[TB] FAIL reset_turn_left: got %0d expected %0d", turn_left, TT);
    end
  endtask

  task automatic test_single();
    logic [1:0] m;
    logic [3:0] r, other;
    int seen;
    for (int it = 0; it < 6; it++) begin
      m = 2'($urandom_range(0, 1));
      doReset(m);
      r     = 4'($urandom_range(1, 15));
      other = 4'($urandom_range(1, 15));
      if (m[0]) begin req2 = r; req1 = other; end
      else      begin req1 = r; req2 = other; end
      cyc();
      req1 = 4'b0; req2 = 4'b0;
      testsRun++;
      if (move_start !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL single_early_start: got %b expected 0", move_start);
      end
      cyc();
      testsRun++;
      if ({move_start, move_dir, move_player, mode} !== {1'b1, expDir(r), m[0], 1'b1, 2'b00, m[0]}) begin
        testsFailed++;
        $display("[TB] FAIL single_grant: got start=%b dir=%b plr=%b mode=%b expected start=1 dir=%b plr=%b mode=100%b",
                 move_start, move_dir, move_player, mode, expDir(r), m[0], m[0]);
      end
      finishMove($urandom_range(1, 8));
      seen = 0;
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      repeat (6) begin cyc(); if (move_start === 1'b1) seen++; end
      testsRun++;
      if (seen != 0) begin
        testsFailed++;
        $display("[TB] FAIL single_other_ignored: got %0d starts expected 0", seen);
      end
      testsRun++;
      if ({mode, turn_left, err} !== {1'b0, 2'b00, m[0], 5'(TT), 1'b0}) begin
        testsFailed++;
        $display("[TB] FAIL single_idle_state: got mode=%b tl=%0d err=%b expected mode=000%b tl=%0d err=0",
                 mode, turn_left, err, m[0], TT);
      end
    end
  endtask

  task automatic test_round_robin();
    doReset(2'b11);
    req1 = 4'b1000; req2 = 4'b0001;
    cyc();
    req1 = 4'b0; req2 = 4'b0;
    cyc();
    testsRun++;
    if ({move_start, move_player, move_dir} !== {1'b1, 1'b0, 4'b1000}) begin
      testsFailed++;
      $display("[TB] FAIL rr_first: got start=%b plr=%b dir=%b expected 1 0 1000",
               move_start, move_player, move_dir);
    end
    cyc();
    finishMove(0);
    cyc();
    testsRun++;
    if (move_start !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rr_gap: got start=%b expected 0 two cycles after done", move_start);
    end
    cyc();
    testsRun++;
    if ({move_start, move_player, move_dir, mode[0]} !== {1'b1, 1'b1, 4'b0001, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL rr_second: got start=%b plr=%b dir=%b mode0=%b expected 1 1 0001 1",
               move_start, move_player, move_dir, mode[0]);
    end
  endtask

  task automatic test_turn_timeout();
    int seen;
    doReset(2'b10);
    testsRun++;
    if ({mode, turn_left} !== {4'b0010, 5'(TT)}) begin
      testsFailed++;
      $display("[TB] FAIL alt_start: got mode=%b tl=%0d expected 0010 %0d", mode, turn_left, TT);
    end
    for (int rnd = 0; rnd < 2; rnd++) begin
      seen = 0;
      for (int i = 0; i < TT; i++) begin
        repeat ($urandom_range(0, 3)) begin cyc(); if (move_start === 1'b1) seen++; end
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        if (i < TT - 1) begin
          testsRun++;
          if (turn_left !== 5'(TT - 1 - i)) begin
            testsFailed++;
            $display("[TB] FAIL alt_countdown: got %0d expected %0d", turn_left, TT - 1 - i);
          end
        end
      end
      cyc();
      testsRun++;
      if ({mode[0], turn_left, move_start} !== {1'(~rnd[0]), 5'(TT), 1'b0} || seen != 0) begin
        testsFailed++;
        $display("[TB] FAIL alt_toggle: got turn=%b tl=%0d starts=%0d expected turn=%b tl=%0d starts=0",
                 mode[0], turn_left, seen + int'(move_start), ~rnd[0], TT);
      end
    end
  endtask

  task automatic test_alternate_drop();
    logic [3:0] r;
    int seen;
    bit ok;
    doReset(2'b10);
    req2 = 4'($urandom_range(1, 15));
    cyc();
    req2 = 4'b0;
    seen = 0;
    repeat (3) begin cyc(); if (move_start === 1'b1) seen++; end
    for (int i = 0; i < TT; i++) begin tick = 1'b1; cyc(); tick = 1'b0; end
    repeat (5) begin cyc(); if (move_start === 1'b1) seen++; end
    testsRun++;
    if (seen != 0 || mode[0] !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL alt_out_of_turn_dropped: got starts=%0d turn=%b expected 0 1", seen, mode[0]);
    end
    r = 4'($urandom_range(1, 15));
    req2 = r;
    cyc();
    req2 = 4'b0;
    waitStart(4, ok);
    testsRun++;
    if (!ok || move_player !== 1'b1 || move_dir !== expDir(r)) begin
      testsFailed++;
      $display("[TB] FAIL alt_p2_grant: got ok=%b plr=%b dir=%b expected 1 1 %b",
               ok, move_player, move_dir, expDir(r));
    end
    finishMove(2);
    cyc();
    testsRun++;
    if ({mode, turn_left} !== {4'b0010, 5'(TT)}) begin
      testsFailed++;
      $display("[TB] FAIL alt_back_to_p1: got mode=%b tl=%0d expected 0010 %0d", mode, turn_left, TT);
    end
  endtask

  task automatic test_watchdog();
    doReset(2'b10);
    req1 = 4'($urandom_range(1, 15));
    cyc();
    req1 = 4'b0;
    cyc();
    testsRun++;
    if (move_start !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL wd_start: got %b expected 1", move_start);
    end
    repeat (DT - 1) cyc();
    testsRun++;
    if ({err, mode[3]} !== 2'b01) begin
      testsFailed++;
      $display("[TB] FAIL wd_before: got err=%b busy=%b expected 0 1 at cycle %0d", err, mode[3], DT - 1);
    end
    cyc();
    testsRun++;
    if ({err, mode[3]} !== 2'b10) begin
      testsFailed++;
      $display("[TB] FAIL wd_expire: got err=%b busy=%b expected 1 0 at cycle %0d", err, mode[3], DT);
    end
    cyc();
    testsRun++;
    if ({mode[0], turn_left} !== {1'b1, 5'(TT)}) begin
      testsFailed++;
      $display("[TB] FAIL wd_turn_pass: got turn=%b tl=%0d expected 1 %0d", mode[0], turn_left, TT);
    end
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    cyc();
    testsRun++;
    if (err !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL wd_err_sticky: got %b expected 1 after restart", err);
    end
  endtask

  task automatic test_game_over();
    logic [1:0] k;
    logic [3:0] r;
    int seen;
    bit ok;
    doReset(2'b10);
    req1 = 4'($urandom_range(1, 15));
    cyc();
    req1 = 4'b0;
    cyc();
    cyc();
    over2 = 1'b1;
    finishMove(2);
    cyc();
    cyc();
    testsRun++;
    if ({winner, mode[2], mode[3]} !== 4'b0110) begin
      testsFailed++;
      $display("[TB] FAIL over_enter: got winner=%b over=%b busy=%b expected 01 1 0", winner, mode[2], mode[3]);
    end
    seen = 0;
    req1 = 4'b0100; req2 = 4'b0010;
    cyc();
    req1 = 4'b0; req2 = 4'b0;
    repeat (3) begin cyc(); if (move_start === 1'b1) seen++; end
    testsRun++;
    if (seen != 0 || winner !== 2'b01) begin
      testsFailed++;
      $display("[TB] FAIL over_hold: got starts=%0d winner=%b expected 0 01", seen, winner);
    end
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    over2 = 1'b0;
    testsRun++;
    if ({winner, mode[2], turn_left} !== {2'b00, 1'b0, 5'(TT)}) begin
      testsFailed++;
      $display("[TB] FAIL over_restart: got winner=%b over=%b tl=%0d expected 00 0 %0d",
               winner, mode[2], turn_left, TT);
    end

    for (int v = 1; v < 4; v++) begin
      k = 2'(v);
      doReset(2'b11);
      req1 = 4'($urandom_range(1, 15));
      cyc();
      req1 = 4'b0;
      over1 = k[1]; over2 = k[0];
      cyc();
      testsRun++;
      if ({move_start, mode[2], winner} !== {1'b0, 1'b1, expWinner(k[1], k[0])}) begin
        testsFailed++;
        $display("[TB] FAIL over_priority: got start=%b over=%b winner=%b expected 0 1 %b",
                 move_start, mode[2], winner, expWinner(k[1], k[0]));
      end
    end

    doReset(2'b01);
    over1 = 1'b1;
    r = 4'($urandom_range(1, 15));
    req2 = r;
    cyc();
    req2 = 4'b0;
    waitStart(4, ok);
    testsRun++;
    if (!ok || move_player !== 1'b1 || move_dir !== expDir(r)) begin
      testsFailed++;
      $display("[TB] FAIL single_other_over_ignored: got ok=%b plr=%b dir=%b expected 1 1 %b",
               ok, move_player, move_dir, expDir(r));
    end
    finishMove(1);
    over2 = 1'b1;
    cyc();
    cyc();
    testsRun++;
    if ({mode, winner} !== {4'b0101, 2'b00}) begin
      testsFailed++;
      $display("[TB] FAIL single_over: got mode=%b winner=%b expected 0101 00", mode, winner);
    end
  endtask

  task automatic test_reset_mid_move();
    logic [3:0] r;
    doReset(2'b11);
    req2 = 4'($urandom_range(1, 15));
    cyc();
    req2 = 4'b0;
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    testsRun++;
    if ({move_start, move_dir, move_player, mode, winner, err} !== 13'b0 || turn_left !== 5'(TT)) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_move: got %b tl=%0d expected all zero tl=%0d",
               {move_start, move_dir, move_player, mode, winner, err}, turn_left, TT);
    end
    cyc();
    rst_n = 1'b1;
    cyc();
    r = 4'($urandom_range(1, 15));
    req1 = r;
    cyc();
    req1 = 4'b0;
    cyc();
    testsRun++;
    if ({move_start, move_player, move_dir} !== {1'b1, 1'b0, expDir(r)}) begin
      testsFailed++;
      $display("[TB] FAIL reset_then_serve: got start=%b plr=%b dir=%b expected 1 0 %b",
               move_start, move_player, move_dir, expDir(r));
    end
  endtask

  // Round-robin model: each round's pending players in grant order, pointer
  // moving to the non-granted player after every move
  task automatic test_random_rr();
    int rrModel, press, order[$], seen, g;
    logic [3:0] dirs[2];
    bit ok;
    doReset(2'b11);
    rrModel = 0;
    for (int round = 0; round < 12; round++) begin
      testsRun++;
      if (mode !== {3'b001, 1'(rrModel)}) begin
        testsFailed++;
        $display("[TB] FAIL rand_rr_idle: got mode=%b expected 001%0d", mode, rrModel);
      end
      press = $urandom_range(1, 3);
      dirs[0] = 4'($urandom_range(1, 15));
      dirs[1] = 4'($urandom_range(1, 15));
      req1 = press[0] ? dirs[0] : 4'b0;
      req2 = press[1] ? dirs[1] : 4'b0;
      order.delete();
      if (press == 3) begin order.push_back(rrModel); order.push_back(1 - rrModel); end
      else            order.push_back(press == 1 ? 0 : 1);
      cyc();
      req1 = 4'b0; req2 = 4'b0;
      while (order.size() > 0) begin
        g = order.pop_front();
        waitStart(6, ok);
        testsRun++;
        if (!ok || move_player !== 1'(g) || move_dir !== expDir(dirs[g])) begin
          testsFailed++;
          $display("[TB] FAIL rand_rr_grant: round %0d got ok=%b plr=%b dir=%b expected 1 %0d %b",
                   round, ok, move_player, move_dir, g, expDir(dirs[g]));
        end
        cyc();
        if ($urandom_range(0, 1) == 1) begin
          if (g == 0) req1 = 4'($urandom_range(1, 15));
          else        req2 = 4'($urandom_range(1, 15));
        end
        cyc();
        req1 = 4'b0; req2 = 4'b0;
        finishMove($urandom_range(0, 4));
        rrModel = 1 - g;
      end
      seen = 0;
      repeat (4) begin cyc(); if (move_start === 1'b1) seen++; end
      testsRun++;
      if (seen != 0) begin
        testsFailed++;
        $display("[TB] FAIL rand_rr_drop: round %0d got %0d extra starts expected 0", round, seen);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_turn_timeout();
    test_alternate_drop();
    test_watchdog();
    test_game_over();
    test_reset_mid_move();
    test_random_rr();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/player_arbiter.md
# player_arbiter

Turn and move scheduler for the two-board 2048 game. It latches direction requests from both players' keypads and grants one move at a time to the shared move engine, with a start/done handshake. It enforces alternating or round-robin turn rules, a per-turn timeout and game-over detection. It drives the 4-bit `mode` word that the board/judge selector uses to choose which player's 64-bit board and 16-bit judge vector reach the display.

## Interface
- `TURN_TICKS`, default 30: per-turn budget in `tick` pulses (versus-alternating only), 1..31.
- `DONE_TIMEOUT`, default 255: clock cycles allowed for `move_done`, 1..255.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-cycle timebase strobe.
- `mode_sel`  in  2  game type:
  - 00: single, player 1
  - 01: single, player 2
  - 10: versus, alternating turns
  - 11: versus, round-robin
- `restart`  in  1  one-cycle pulse; returns to IDLE.
- `req1`, `req2`  in  4  debounced key pulses {up,down,left,right}.
- `move_done`  in  1  one-cycle pulse from the move engine.
- `over1`, `over2`  in  1  game-over level per board.
- `move_start`  out  1  one-cycle command strobe.
- `move_dir`  out  4  one-hot direction.
- `move_player`  out  1  target board (0 = player 1).
- `mode`  out  4  bit0 displayed player; bit1 versus; bit2 game over; bit3 busy.
- `turn_left`  out  5  remaining ticks of the current turn.
- `winner`  out  2  01 = p1, 10 = p2, 11 = draw, 00 = none or single.
- `err`  out  1  sticky; set on handshake timeout.

## Operation
- Reset: state IDLE; pending slots empty; rr pointer = p1; turn = p1. Outputs: all 0 except `turn_left` = TURN_TICKS.
- Pending slots, one per player:
  - A nonzero `reqX` loads the slot only when the slot is empty.
  - Multi-bit requests are reduced by priority up > down > left > right.
  - Requests arriving while the slot is full are dropped.
  - Requests from the player whose move is in flight (ISSUE/WAIT_DONE) are dropped.
  - In mode 10, requests from the player not holding the turn are dropped.
- FSM states:
  - IDLE: sample `mode_sel` into a held register; clear slots; next state GRANT.
  - GRANT, evaluated in this order:
    1. Game-over check.
       - Single mode: the active player's `over` → OVER, `winner` = 00.
       - Versus: either `over` → OVER; `winner` = 01 if only `over2`, 10 if only `over1`, 11 if both.
    2. Eligible slot present → ISSUE.
       - Modes 00/01 and 10: only the active/turn player's slot is eligible.
       - Mode 11: if both slots are full, the rr pointer's player wins; otherwise whichever slot is full.
    3. Mode 10 and `tick` with `turn_left` = 1 → SWITCH with no move.
  - ISSUE: `move_start` = 1 for exactly one cycle; granted slot cleared; next state WAIT_DONE.
  - WAIT_DONE:
    - `move_done` → SWITCH.
    - Watchdog reaching DONE_TIMEOUT → set `err`, go to SWITCH.
  - SWITCH, one cycle:
    - Mode 11: rr pointer becomes the non-granted player.
    - Mode 10: turn toggles and `turn_left` reloads to TURN_TICKS.
    - Next state GRANT.
  - OVER: hold all outputs; exit only via `restart` or reset.
- `restart` overrides any state → IDLE next cycle. It clears `winner` and `turn_left` (reloaded to TURN_TICKS) and cancels any in-flight move. `err` is cleared only by reset.
- `move_dir` and `move_player` are registered at the GRANT→ISSUE transition and held until the next grant.
- `mode` bits:
  - bit0: `move_player` while busy. Otherwise: the turn player in mode 10, the rr pointer's player in mode 11, and `mode_sel[0]` in single mode.
  - bit3: 1 in ISSUE and WAIT_DONE.
- `mode_sel` changes outside IDLE are ignored until the next `restart`.

## Timing
- A request pulse in cycle N (state GRANT, slot empty) gives slot full at N+1, and the GRANT decision at N+1. `move_start` is high in N+2.
- `move_done` in cycle M gives SWITCH in M+1 and GRANT in M+2. A pending slot is therefore issued no earlier than M+3.
- `turn_left` decrements on each `tick` in GRANT in mode 10 only, and is frozen while busy.
- `tick` and `move_done` in the same cycle: `move_done` wins. The turn does not time out during a move.
- Game-over has priority over a simultaneous eligible request in GRANT.
- Watchdog counts cycles in WAIT_DONE, reset on entry. A timeout also yields SWITCH exactly DONE_TIMEOUT cycles after `move_start`.
- `rst_n` asserted mid-move drops `move_start` and `mode` immediately; no completion is expected.

## Test plan
- Mode 00, `req1` = 0101 → `move_start` 2 cycles later, `move_dir` = 0100, `move_player` = 0; `req2` ignored.
- Mode 11, `req1` = 1000 and `req2` = 0001 in the same cycle → p1 is granted first. After `move_done`, p2 is granted with `move_dir` = 0001 and `mode[0]` = 1.
- Mode 10, TURN_TICKS = 3, no requests, 3 ticks → turn toggles to p2, `turn_left` = 3, `move_start` stays 0.
- Mode 10, `move_done` withheld, DONE_TIMEOUT = 255 → `err` = 1 at cycle 255 after `move_start`, then the turn passes to p2.
- Versus, `over2` raised while p1's move is in flight → after SWITCH the FSM enters OVER, `winner` = 01, `mode[2]` = 1. `restart` → IDLE, `winner` = 00.
- `rst_n` = 0 during WAIT_DONE → all outputs 0 and `turn_left` = TURN_TICKS in the same cycle. First request after release is serviced normally.
